// File: rtl/data_memory_lsu.sv
// Word-organised data memory with integrated load/store unit.
// After reset, a sequential sweep writes CLEAR_VALUE to every word before
// accesses are honoured. Misaligned H/W accesses are suppressed and latch a
// sticky error flag.
module data_memory_lsu #(
  parameter int unsigned DEPTH_LOG2  = 6,
  parameter logic [31:0] CLEAR_VALUE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        WE,
  input  logic [2:0]  Funct3,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        Ready,
  output logic        MisalignErr
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  state_t                state_q;
  logic [DEPTH_LOG2-1:0] ptr_q;
  logic                  ready_q;
  logic                  err_q;
  logic [31:0]           mem_q [DEPTH];

  logic [DEPTH_LOG2-1:0] idx;
  logic [1:0]            lane;
  logic                  misalign;
  logic [3:0]            wmask;
  logic [31:0]           wdata;
  logic [31:0]           word;
  logic [7:0]            bsel;
  logic [15:0]           hsel;
  logic                  unused_addr;

  // Upper address bits alias onto the same words.
  assign idx         = A[DEPTH_LOG2+1:2];
  assign lane        = A[1:0];
  assign unused_addr = ^A[31:DEPTH_LOG2+2];

  // Misalignment only applies to half-word and word access types.
  always_comb begin
    misalign = 1'b0;
    case (Funct3)
      3'b001, 3'b101: misalign = A[0];
      3'b010:         misalign = |A[1:0];
      default:        misalign = 1'b0;
    endcase
  end

  // Store lane mask and lane-replicated data; suppressed outside legal RUN stores.
  always_comb begin
    wmask = '0;
    wdata = '0;
    case (Funct3)
      3'b000: begin
        wmask = 4'b0001 << lane;
        wdata = {4{WD[7:0]}};
      end
      3'b001: begin
        wmask = A[1] ? 4'b1100 : 4'b0011;
        wdata = {2{WD[15:0]}};
      end
      3'b010: begin
        wmask = '1;
        wdata = WD;
      end
      default: begin
        wmask = '0;
        wdata = '0;
      end
    endcase
    if (!WE || misalign || (state_q != RUN)) begin
      wmask = '0;
    end
  end

  // Sweep/run sequencing with registered Ready and sticky misalignment flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          ptr_q <= ptr_q + 1'b1;
          if (ptr_q == '1) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: begin
          if (misalign) begin
            err_q <= 1'b1;
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  // Memory array: sweep writes during CLEAR, byte-masked stores during RUN.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == CLEAR) begin
        mem_q[ptr_q] <= CLEAR_VALUE;
      end else begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (wmask[b]) begin
            mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
          end
        end
      end
    end
  end

  // Lane selection for loads.
  always_comb begin
    word = mem_q[idx];
    hsel = A[1] ? word[31:16] : word[15:0];
    case (lane)
      2'd0:    bsel = word[7:0];
      2'd1:    bsel = word[15:8];
      2'd2:    bsel = word[23:16];
      default: bsel = word[31:24];
    endcase
  end

  // Extended load data; zero during the sweep, on misalignment or illegal types.
  always_comb begin
    RD = '0;
    if ((state_q == RUN) && !misalign) begin
      case (Funct3)
        3'b000:  RD = {{24{bsel[7]}}, bsel};
        3'b100:  RD = {24'h0, bsel};
        3'b001:  RD = {{16{hsel[15]}}, hsel};
        3'b101:  RD = {16'h0, hsel};
        3'b010:  RD = word;
        default: RD = '0;
      endcase
    end
  end

  assign Ready       = ready_q;
  assign MisalignErr = err_q;

endmodule

// File: tb/tb_data_memory_lsu.sv
// Directed scoreboard bench for data_memory_lsu.
module tb_data_memory_lsu;

  logic        clk;
  logic        reset;
  logic        WE;
  logic [2:0]  Funct3;
  logic [31:0] A;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        Ready;
  logic        MisalignErr;

  int checks = 0;
  int errors = 0;
  int cnt;

  string       tag_q[$];
  logic [31:0] exp_q[$];

  data_memory_lsu #(
    .DEPTH_LOG2 (6),
    .CLEAR_VALUE(32'h0000_0000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .WE         (WE),
    .Funct3     (Funct3),
    .A          (A),
    .WD         (WD),
    .RD         (RD),
    .Ready      (Ready),
    .MisalignErr(MisalignErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [31:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h expected=none", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  task automatic drive(input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    WE = we; Funct3 = f3; A = addr; WD = wd;
    #1;
  endtask

  task automatic ld(input string tag, input logic [2:0] f3,
                    input logic [31:0] addr, input logic [31:0] exp);
    push(tag, exp);
    drive(1'b0, f3, addr, 32'h0);
    pop_cmp(RD);
  endtask

  task automatic st(input logic [2:0] f3, input logic [31:0] addr,
                    input logic [31:0] wd);
    drive(1'b1, f3, addr, wd);
  endtask

  task automatic chk_flag(input string tag, input logic exp);
    push(tag, {31'h0, exp});
    pop_cmp({31'h0, MisalignErr});
  endtask

  // Counts rising edges after reset release until Ready is seen, bounded.
  task automatic wait_ready(output int n);
    n = 0;
    while (Ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1; WE = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; WE = 1'b0; Funct3 = 3'b010; A = 32'h0; WD = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    push("init_ready_cycles", 32'd64);
    wait_ready(cnt);
    pop_cmp(cnt);

    // Garbage before a second reset.
    st(3'b010, 32'h00, 32'hA5A5_A5A5);
    st(3'b010, 32'h7C, 32'h5A5A_5A5A);
    st(3'b010, 32'hFC, 32'hFFFF_0000);
    ld("garbage_fc", 3'b010, 32'hFC, 32'hFFFF_0000);

    // Reset sweep, with a store attempted throughout the sweep.
    @(negedge clk);
    reset = 1'b1; WE = 1'b0; Funct3 = 3'b010; A = 32'hFC;
    @(negedge clk);
    reset = 1'b0;
    #1;
    push("clear_ready0", 32'h0);     pop_cmp({31'h0, Ready});
    push("clear_err0", 32'h0);       pop_cmp({31'h0, MisalignErr});
    push("clear_rd0", 32'h0);        pop_cmp(RD);
    WE = 1'b1; Funct3 = 3'b010; A = 32'h00; WD = 32'h0BAD_BAD0;
    push("sweep_ready_cycles", 32'd64);
    wait_ready(cnt);
    WE = 1'b0;
    pop_cmp(cnt);
    ld("swept_00", 3'b010, 32'h00, 32'h0);
    ld("swept_7c", 3'b010, 32'h7C, 32'h0);
    ld("swept_fc", 3'b010, 32'hFC, 32'h0);

    // Reset re-asserted at sweep cycle 30.
    pulse_reset();
    repeat (29) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    push("restart_ready_cycles", 32'd64);
    wait_ready(cnt);
    pop_cmp(cnt);

    // Word store with read-during-write, then aliasing.
    push("rdw_old", 32'h0);
    drive(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
    pop_cmp(RD);
    ld("lw_10", 3'b010, 32'h10, 32'hDEAD_BEEF);
    ld("lw_alias_110", 3'b010, 32'h110, 32'hDEAD_BEEF);

    // Byte and half masking.
    st(3'b010, 32'h20, 32'h1122_3344);
    st(3'b000, 32'h22, 32'hFFFF_FFA5);
    st(3'b001, 32'h20, 32'h1234_BEEF);
    ld("mask_lw_20", 3'b010, 32'h20, 32'h11A5_BEEF);

    // Sign/zero extension.
    st(3'b010, 32'h30, 32'h80FF_7F01);
    ld("lb_30",  3'b000, 32'h30, 32'h0000_0001);
    ld("lb_31",  3'b000, 32'h31, 32'h0000_007F);
    ld("lb_32",  3'b000, 32'h32, 32'hFFFF_FFFF);
    ld("lbu_32", 3'b100, 32'h32, 32'h0000_00FF);
    ld("lb_33",  3'b000, 32'h33, 32'hFFFF_FF80);
    ld("lbu_33", 3'b100, 32'h33, 32'h0000_0080);
    ld("lh_32",  3'b001, 32'h32, 32'hFFFF_80FF);
    ld("lhu_32", 3'b101, 32'h32, 32'h0000_80FF);
    ld("lh_30",  3'b001, 32'h30, 32'h0000_7F01);

    // Illegal Funct3 values do not write and read back as zero.
    st(3'b010, 32'h50, 32'hCAFE_F00D);
    push("illegal_rd", 32'h0);
    drive(1'b1, 3'b011, 32'h50, 32'hFFFF_FFFF);
    pop_cmp(RD);
    st(3'b110, 32'h50, 32'h1111_1111);
    ld("illegal_lw_50", 3'b010, 32'h50, 32'hCAFE_F00D);
    ld("illegal_f7", 3'b111, 32'h50, 32'h0);
    chk_flag("illegal_err", 1'b0);

    // Misaligned store suppressed; sticky flag.
    push("mis_sw_rd", 32'h0);
    drive(1'b1, 3'b010, 32'h41, 32'h1234_5678);
    pop_cmp(RD);
    chk_flag("mis_err_same_cycle", 1'b0);
    ld("mis_lw_40", 3'b010, 32'h40, 32'h0);
    chk_flag("mis_err_set", 1'b1);
    ld("mis_lh_43", 3'b001, 32'h43, 32'h0);
    ld("aligned_after", 3'b010, 32'h30, 32'h80FF_7F01);
    ld("aligned_after2", 3'b000, 32'h31, 32'h0000_007F);
    chk_flag("mis_err_sticky", 1'b1);

    // Only reset clears the flag; a misaligned load alone also sets it.
    pulse_reset();
    chk_flag("err_cleared", 1'b0);
    wait_ready(cnt);
    ld("mis_load_rd", 3'b101, 32'h21, 32'h0);
    chk_flag("mis_load_err_pending", 1'b0);
    ld("post_mis_load", 3'b010, 32'h20, 32'h0);
    chk_flag("mis_load_err_set", 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_memory_lsu.md
Name: data_memory_lsu

Overview:
- Word-organised data memory with an integrated load/store unit for the RISC-V single-cycle core.
- Sits directly downstream of the ALU: the ALU Result drives the byte address, and RD2 supplies store data.
- Performs byte, half-word and word stores with lane masking, and sign- or zero-extended loads.
- After every reset it runs a sequential clear sweep and flags misaligned accesses.

Parameters:
- DEPTH_LOG2, 6: log2 of the number of 32-bit words (default 64 words = 256 bytes).
- CLEAR_VALUE, 32'h00000000: value written to every word during the post-reset sweep.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- WE  input  1  store enable from the control unit.
- Funct3  input  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- A  input  32  byte address (ALU Result).
- WD  input  32  store data; the low byte or half is used for B/H stores.
- RD  output  32  extended load data (combinational).
- Ready  output  1  1 when the sweep is done and accesses are honoured.
- MisalignErr  output  1  sticky misalignment flag.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled on the rising edge of clk.
- Addressing:
  - Word index = A[DEPTH_LOG2+1:2]. Upper address bits are ignored, so accesses alias (wrap) modulo 2^(DEPTH_LOG2+2) bytes.
  - Byte lane = A[1:0].
- State machine: two states, CLEAR and RUN.
  - reset high at an edge: go to CLEAR, sweep pointer <= 0, Ready <= 0, MisalignErr <= 0.
  - CLEAR: each cycle write CLEAR_VALUE to word[ptr] and increment ptr. The cycle that writes word 2^DEPTH_LOG2-1 transitions to RUN.
  - Ready rises exactly 2^DEPTH_LOG2 cycles after the first edge with reset low (64 cycles by default).
  - RUN: stays in RUN until reset.
  - reset asserted mid-sweep restarts the sweep at word 0.
- Output values in CLEAR:
  - RD = 0.
  - WE is ignored; no store occurs.
  - MisalignErr holds 0.
- Reset values: RD = 0, Ready = 0, MisalignErr = 0.
- Loads (RUN; RD is valid every cycle, combinational from A and Funct3):
  - 000 LB: sign-extend the byte at lane A[1:0].
  - 100 LBU: zero-extend the same byte.
  - 001 LH: sign-extend half A[1]. 101 LHU: zero-extend half A[1].
  - 010 LW: full word.
  - 011, 110, 111: RD = 0.
- Stores (RUN, WE=1, written at the rising edge):
  - 000 SB: write WD[7:0] into lane A[1:0] only.
  - 001 SH: write WD[15:0] into half A[1] only.
  - 010 SW: write the full word.
  - Other Funct3 values: no write.
- Read-during-write: in the same cycle and at the same address, RD shows the pre-edge (old) data. The new data is visible from the next cycle.
- Misalignment:
  - H/HU access with A[0]=1, or W with A[1:0]!=00, is misaligned. This applies whether or not WE is asserted.
  - A misaligned store is suppressed; memory is unchanged.
  - A misaligned load returns RD = 0.
  - MisalignErr sets at the edge following the access and stays at 1 until reset. Later aligned accesses do not clear it.
- No other state: memory contents persist across RUN cycles and are overwritten only by the sweep or by legal stores.

Test Plan:
- Reset sweep:
  - Stimulus: pre-load garbage via SW before reset, pulse reset for 1 cycle.
  - Required: Ready=0 for exactly 64 cycles, then 1. LW from 0x00, 0x7C and 0xFC all return 0.
  - Second case: reasserting reset at sweep cycle 30 delays Ready to 64 cycles after the reset release.
- Word store/load:
  - Stimulus: SW 0xDEADBEEF to 0x10, then LW 0x10.
  - Required: RD=0xDEADBEEF, and RD showed old data (0) during the store cycle.
  - Aliasing: LW 0x110 also returns 0xDEADBEEF.
- Byte/half masking:
  - Stimulus: SW 0x11223344 at 0x20, SB WD=0xA5 at 0x22, SH WD=0xBEEF at 0x20.
  - Required: LW 0x20 = 0x11A5BEEF.
- Extension:
  - Stimulus: word at 0x30 = 0x80FF7F01.
  - Required:
    - LB 0x30=0x00000001, LB 0x31=0x0000007F, LB 0x32=0xFFFFFFFF, LBU 0x32=0x000000FF.
    - LH 0x32=0xFFFF80FF, LHU 0x32=0x000080FF, LH 0x30=0x00007F01.
- Misalignment:
  - Stimulus: SW 0x12345678 to 0x41, where word 0x40 holds 0x00000000.
  - Required: LW 0x40 = 0, MisalignErr=1 from the next cycle and held through later aligned accesses.
  - Also: LH 0x43 gives RD=0. Only reset clears the flag.
- Illegal Funct3:
  - Stimulus: WE=1, Funct3=011 at 0x50 holding 0xCAFEF00D.
  - Required: word unchanged, a load with Funct3=111 returns 0, MisalignErr unaffected.
